// File: rtl/dmix_pkg.sv
// Shared sample definitions for the mixer/resampler datapath.
package dmix_pkg;

  localparam int unsigned SAMPLE_W = 24;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/ringbuf_array_if.sv
// Bus bundle for ringbuf_array: writer/reader strobes in, read data and status out.
interface ringbuf_array_if
  import dmix_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DEPTH_LOG2 = 5
);

  logic [NUM_CH-1:0]                  push_i;
  logic [SAMPLE_W*NUM_CH-1:0]         wdata_i;
  logic [NUM_CH-1:0]                  pop_i;
  logic [DEPTH_LOG2*NUM_CH-1:0]       offset_i;
  logic [SAMPLE_W*NUM_CH-1:0]         rdata_o;
  logic [(DEPTH_LOG2+1)*NUM_CH-1:0]   count_o;
  logic [NUM_CH-1:0]                  full_o;
  logic [NUM_CH-1:0]                  empty_o;
  logic [NUM_CH-1:0]                  overflow_o;
  logic [NUM_CH-1:0]                  underflow_o;

  modport master (
    output push_i, wdata_i, pop_i, offset_i,
    input  rdata_o, count_o, full_o, empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, wdata_i, pop_i, offset_i,
    output rdata_o, count_o, full_o, empty_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/ringbuf_ch.sv
// One channel of the sample history ring: storage, pointers, occupancy,
// sticky error flags and a registered random-access read port.
module ringbuf_ch
  import dmix_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  sample_t               wdata,
  input  logic                  pop,
  input  logic [DEPTH_LOG2-1:0] offset,
  output sample_t               rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  sample_t               mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2-1:0] raddr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign raddr = rptr + offset;

  // A pop on a full ring frees the slot the same-cycle push lands in.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        wptr <= wptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
      overflow  <= overflow  | (push && full && !pop);
      underflow <= underflow | (pop && empty);
      rdata     <= mem[raddr];
    end
  end

endmodule

// File: rtl/ringbuf_array.sv
// Multi-channel sample history buffer feeding the resampler; one independent
// ringbuf_ch per channel, this level only slices the flat buses.
module ringbuf_array
  import dmix_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned NUM_CH_LOG2 = 3,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned DEPTH_LOG2  = 5
) (
  input logic            clk,
  input logic            rst,
  ringbuf_array_if.slave bus
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  if (NUM_CH > (32'd1 << NUM_CH_LOG2) || DEPTH != (32'd1 << DEPTH_LOG2)) begin : g_param_check
    $error("ringbuf_array: inconsistent size parameters");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ringbuf_ch #(
      .DEPTH      (DEPTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.push_i[c]),
      .wdata     (bus.wdata_i[SAMPLE_W*c +: SAMPLE_W]),
      .pop       (bus.pop_i[c]),
      .offset    (bus.offset_i[DEPTH_LOG2*c +: DEPTH_LOG2]),
      .rdata     (bus.rdata_o[SAMPLE_W*c +: SAMPLE_W]),
      .count     (bus.count_o[CW*c +: CW]),
      .full      (bus.full_o[c]),
      .empty     (bus.empty_o[c]),
      .overflow  (bus.overflow_o[c]),
      .underflow (bus.underflow_o[c])
    );
  end

endmodule

// File: tb/tb_ringbuf_array.sv
// Scoreboard bench for ringbuf_array: a queue-per-channel model predicts each
// edge's read data and status; a monitor compares after every rising edge.
module tb_ringbuf_array;
  import dmix_pkg::*;

  localparam int unsigned NCH   = 8;
  localparam int unsigned DL    = 5;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ringbuf_array_if #(.NUM_CH(NCH), .DEPTH_LOG2(DL)) bus ();

  ringbuf_array #(
    .NUM_CH      (NCH),
    .NUM_CH_LOG2 (3),
    .DEPTH       (DEPTH),
    .DEPTH_LOG2  (DL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned edge_n;
    int unsigned ch;
    bit          dv;
    logic [23:0] data;
    int unsigned cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] mq [NCH][$];
  bit          m_ovf [NCH];
  bit          m_unf [NCH];

  int unsigned edges  = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [NCH-1:0] s_push;
  logic [NCH-1:0] s_pop;
  logic [23:0]    s_wd  [NCH];
  logic [4:0]     s_off [NCH];

  task automatic clear_stim();
    s_push = '0;
    s_pop  = '0;
    for (int c = 0; c < NCH; c++) begin
      s_wd[c]  = '0;
      s_off[c] = '0;
    end
  endtask

  // Drive one cycle of stimulus and predict the state after the next edge.
  task automatic step(input bit r);
    @(negedge clk);
    rst         = r;
    bus.push_i  = s_push;
    bus.pop_i   = s_pop;
    for (int c = 0; c < NCH; c++) begin
      bus.wdata_i[24*c +: 24] = s_wd[c];
      bus.offset_i[5*c +: 5]  = s_off[c];
    end
    for (int c = 0; c < NCH; c++) begin
      exp_t        e;
      int unsigned sz;
      e.edge_n = edges + 1;
      e.ch     = c;
      sz       = mq[c].size();
      if (r) begin
        mq[c].delete();
        m_ovf[c] = 1'b0;
        m_unf[c] = 1'b0;
        e.dv     = 1'b1;
        e.data   = '0;
      end else begin
        e.dv   = (int'(s_off[c]) < sz);
        e.data = e.dv ? mq[c][s_off[c]] : '0;
        if (s_push[c] && sz == DEPTH && !s_pop[c]) m_ovf[c] = 1'b1;
        if (s_pop[c] && sz == 0) m_unf[c] = 1'b1;
        if (s_pop[c] && sz > 0) void'(mq[c].pop_front());
        if (s_push[c] && mq[c].size() < DEPTH) mq[c].push_back(s_wd[c]);
      end
      e.cnt = mq[c].size();
      e.ovf = m_ovf[c];
      e.unf = m_unf[c];
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    edges++;
    while (exp_q.size() > 0 && exp_q[0].edge_n == edges) begin
      exp_t        e;
      logic [23:0] act_d;
      logic [9:0]  act_s;
      logic [9:0]  exp_s;
      e = exp_q.pop_front();
      if (e.dv) begin
        checks++;
        act_d = bus.rdata_o[24*e.ch +: 24];
        if (act_d !== e.data) begin
          errors++;
          $display("FAIL rdata ch%0d edge %0d: got %h expected %h", e.ch, edges, act_d, e.data);
        end
      end
      checks++;
      act_s = {bus.count_o[6*e.ch +: 6], bus.full_o[e.ch], bus.empty_o[e.ch],
               bus.overflow_o[e.ch], bus.underflow_o[e.ch]};
      exp_s = {6'(e.cnt), e.cnt == DEPTH, e.cnt == 0, e.ovf, e.unf};
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL status ch%0d edge %0d: got cnt/full/empty/ovf/unf %b expected %b",
                 e.ch, edges, act_s, exp_s);
      end
    end
  end

  initial begin
    bus.push_i   = '0;
    bus.pop_i    = '0;
    bus.wdata_i  = '0;
    bus.offset_i = '0;
    clear_stim();
    step(1'b1);
    step(1'b1);

    // ch0: five pushes, then read them back by offset
    for (int i = 1; i <= 5; i++) begin
      clear_stim(); s_push[0] = 1'b1; s_wd[0] = 24'(i); step(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      clear_stim(); s_off[0] = 5'(i); step(1'b0);
    end

    // ch3: fill, overflow, then push+pop while full
    for (int i = 0; i < 32; i++) begin
      clear_stim(); s_push[3] = 1'b1; s_wd[3] = 24'($urandom()); step(1'b0);
    end
    clear_stim(); s_push[3] = 1'b1; s_wd[3] = 24'hABCDEF; step(1'b0);
    clear_stim(); s_off[3] = 5'd31; step(1'b0);
    clear_stim(); s_push[3] = 1'b1; s_pop[3] = 1'b1; s_wd[3] = 24'h5A5A5A; step(1'b0);
    clear_stim(); s_off[3] = 5'd31; step(1'b0);
    clear_stim(); s_off[3] = 5'd0;  step(1'b0);

    // ch7: pop on empty, then push+pop on empty
    clear_stim(); s_pop[7] = 1'b1; step(1'b0);
    clear_stim(); s_push[7] = 1'b1; s_pop[7] = 1'b1; s_wd[7] = 24'h123456; step(1'b0);
    clear_stim(); s_off[7] = 5'd0; step(1'b0);

    // ch1: prime 4, then sliding window past the wrap point
    for (int i = 0; i < 4; i++) begin
      clear_stim(); s_push[1] = 1'b1; s_wd[1] = 24'($urandom()); step(1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      clear_stim(); s_push[1] = 1'b1; s_pop[1] = 1'b1;
      s_wd[1] = 24'($urandom()); s_off[1] = 5'(i % 4); step(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      clear_stim(); s_off[1] = 5'(i); step(1'b0);
    end

    // same pattern with reset landing mid-stream
    for (int i = 0; i < 30; i++) begin
      clear_stim(); s_push[1] = 1'b1; s_pop[1] = 1'b1;
      s_wd[1] = 24'($urandom()); s_off[1] = 5'(i % 4); step(i == 20);
    end

    // all channels concurrently, distinct data per channel
    for (int i = 0; i < 6; i++) begin
      clear_stim();
      for (int c = 0; c < NCH; c++) begin
        s_push[c] = 1'b1;
        s_wd[c]   = 24'((c << 20) | (i << 8) | 'h5A);
        s_off[c]  = 5'($urandom_range(0, i));
      end
      step(1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      clear_stim();
      for (int c = 0; c < NCH; c++) s_off[c] = 5'(i);
      step(1'b0);
    end

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      clear_stim();
      for (int c = 0; c < NCH; c++) begin
        s_push[c] = ($urandom_range(0, 99) < 55);
        s_pop[c]  = ($urandom_range(0, 99) < 45);
        s_wd[c]   = 24'($urandom());
        s_off[c]  = 5'($urandom_range(0, 31));
      end
      step($urandom_range(0, 499) == 0);
    end

    clear_stim();
    step(1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
